// File: rtl/three_way_toom_cook_seq_pkg.sv
// Shared constants for the sequential 3-way Toom-Cook (schoolbook limb) GF(2)[x] multiplier:
// state encoding, limb geometry, coefficient indices and the per-product limb-select table.
package tcm_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ASM  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int LW       = 136;
  localparam int LIMB_W   = LW + 1;          // 137: the top limb is one bit wider
  localparam int ACC_W    = 2 * LIMB_W - 1;  // 273: width of one limb product
  localparam int K_W      = 8;
  localparam int P_W      = 4;
  localparam int K_LAST   = LIMB_W - 1;
  localparam int P_LAST   = 8;
  localparam int NUM_COEF = 5;

  // Coefficient slots: d gets shift 4*LW, h gets shift 0
  localparam logic [2:0] COEF_D = 3'd0;
  localparam logic [2:0] COEF_E = 3'd1;
  localparam logic [2:0] COEF_F = 3'd2;
  localparam logic [2:0] COEF_G = 3'd3;
  localparam logic [2:0] COEF_H = 3'd4;

  // Product order p=0..8, packed with p=0 in the least significant field:
  // a2b2, a1b2, a2b1, a0b2, a1b1, a2b0, a0b1, a1b0, a0b0
  localparam logic [17:0] A_SEL_TABLE = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2};
  localparam logic [17:0] B_SEL_TABLE = {2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
  localparam logic [26:0] COEF_TABLE  = {COEF_H, COEF_G, COEF_G, COEF_F, COEF_F, COEF_F,
                                         COEF_E, COEF_E, COEF_D};

  function automatic logic [1:0] a_sel_of(input logic [P_W-1:0] p);
    return A_SEL_TABLE[2*p +: 2];
  endfunction

  function automatic logic [1:0] b_sel_of(input logic [P_W-1:0] p);
    return B_SEL_TABLE[2*p +: 2];
  endfunction

  function automatic logic [2:0] coef_of(input logic [P_W-1:0] p);
    return COEF_TABLE[3*p +: 3];
  endfunction

endpackage

// File: rtl/three_way_toom_cook_seq_clmul.sv
// One bit-serial shift-XOR step of a 137x137 carry-less multiply:
// if bit k of the a-limb is set, the b-limb shifted by k is folded into the accumulator.
module clmul_serial_137
  import tcm_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] i_a_limb,
  input  logic [LIMB_W-1:0] i_b_limb,
  input  logic [K_W-1:0]    i_k,
  input  logic [ACC_W-1:0]  i_acc,
  output logic [ACC_W-1:0]  o_acc
);

  logic             w_a_bit;
  logic [ACC_W-1:0] w_partial;

  assign w_a_bit   = i_a_limb[i_k];
  assign w_partial = ACC_W'(i_b_limb) << i_k;
  assign o_acc     = w_a_bit ? (i_acc ^ w_partial) : i_acc;

endmodule

// File: rtl/three_way_toom_cook_seq.sv
// Sequential carry-less multiplier: operands split into three limbs, the nine limb
// products are accumulated bit-serially into five coefficients, then shifted together.
// Fixed latency: every limb bit is visited regardless of its value.
module three_way_toom_cook_seq
  import tcm_seq_pkg::*;
#(
  parameter int N  = 409,
  parameter int LW = 136
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int C_W = 2 * N;

  state_t           r_state, w_state_next;
  logic [N-1:0]     r_a, r_b;
  logic [K_W-1:0]   r_k;
  logic [P_W-1:0]   r_p;
  logic [C_W-1:0]   r_c;

  logic [LIMB_W-1:0] w_a_limb [3];
  logic [LIMB_W-1:0] w_b_limb [3];
  logic [LIMB_W-1:0] w_a_sel, w_b_sel;
  logic [ACC_W-1:0]  w_coef [NUM_COEF];
  logic [ACC_W-1:0]  w_acc_in, w_acc_out;
  logic [C_W-1:0]    w_c_asm;
  logic              w_accept, w_last_k, w_last_p;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last_k = (r_k == K_W'(K_LAST));
  assign w_last_p = (r_p == P_W'(P_LAST));

  // Limb k covers bits [k*LW +: LW]; the top limb takes whatever remains up to N-1
  for (genvar gi = 0; gi < 3; gi++) begin : g_limb
    localparam int LO = gi * LW;
    localparam int HI = (gi == 2) ? N - 1 : (gi + 1) * LW - 1;
    assign w_a_limb[gi] = LIMB_W'(r_a[HI:LO]);
    assign w_b_limb[gi] = LIMB_W'(r_b[HI:LO]);
  end

  // Select the limb pair and coefficient slot for the current product index
  always_comb begin
    w_a_sel  = '0;
    w_b_sel  = '0;
    w_acc_in = '0;
    case (a_sel_of(r_p))
      2'd0:    w_a_sel = w_a_limb[0];
      2'd1:    w_a_sel = w_a_limb[1];
      2'd2:    w_a_sel = w_a_limb[2];
      default: w_a_sel = '0;
    endcase
    case (b_sel_of(r_p))
      2'd0:    w_b_sel = w_b_limb[0];
      2'd1:    w_b_sel = w_b_limb[1];
      2'd2:    w_b_sel = w_b_limb[2];
      default: w_b_sel = '0;
    endcase
    case (coef_of(r_p))
      COEF_D:  w_acc_in = w_coef[0];
      COEF_E:  w_acc_in = w_coef[1];
      COEF_F:  w_acc_in = w_coef[2];
      COEF_G:  w_acc_in = w_coef[3];
      COEF_H:  w_acc_in = w_coef[4];
      default: w_acc_in = '0;
    endcase
  end

  clmul_serial_137 u_step (
    .i_a_limb (w_a_sel),
    .i_b_limb (w_b_sel),
    .i_k      (r_k),
    .i_acc    (w_acc_in),
    .o_acc    (w_acc_out)
  );

  // One register per coefficient; only the slot addressed by p is updated in MAC
  for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef
    logic [ACC_W-1:0] r_coef;
    // Clear on accept, accumulate when this slot is the current target
    always_ff @(posedge clk) begin
      if (rst) begin
        r_coef <= '0;
      end else if (w_accept) begin
        r_coef <= '0;
      end else if (r_state == S_MAC && coef_of(r_p) == 3'(gi)) begin
        r_coef <= w_acc_out;
      end
    end
    assign w_coef[gi] = r_coef;
  end

  // Final assembly: h + g*x^LW + f*x^2LW + e*x^3LW + d*x^4LW, truncated to 2N bits
  assign w_c_asm = C_W'(w_coef[COEF_H])
                 ^ (C_W'(w_coef[COEF_G]) << LW)
                 ^ (C_W'(w_coef[COEF_F]) << (2 * LW))
                 ^ (C_W'(w_coef[COEF_E]) << (3 * LW))
                 ^ (C_W'(w_coef[COEF_D]) << (4 * LW));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_MAC;
      S_MAC:   if (w_last_p && w_last_k) w_state_next = S_ASM;
      S_ASM:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bit counter k and product index p; k wraps 136->0 while p advances
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_k <= '0;
      r_p <= '0;
    end else if (r_state == S_MAC) begin
      if (w_last_k) begin
        r_k <= '0;
        r_p <= w_last_p ? '0 : r_p + P_W'(1);
      end else begin
        r_k <= r_k + K_W'(1);
      end
    end
  end

  // Operand capture on the accepting edge only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Result register: loaded in ASM, held otherwise (a new start leaves it intact)
  always_ff @(posedge clk) begin
    if (rst)                   r_c <= '0;
    else if (r_state == S_ASM) r_c <= w_c_asm;
  end

  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_DONE);
  assign c     = r_c;

endmodule
